// File: rtl/blink_defs.sv
// Shared definitions for the LED blink / debounce blocks: FSM encoding,
// default ms timebase and a counter-width helper.
package blink_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int DEF_TICK_COUNT = 100_000;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond timebase: counts 0..TICK_COUNT-1 and flags the last cycle.
// i_clear forces the count back to 0 on the next edge.
module ms_prescaler
    import blink_defs::*;
#(
    parameter int TICK_COUNT = DEF_TICK_COUNT
) (
    input  logic i_ck,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              W    = cnt_w(TICK_COUNT);
    localparam logic [W-1:0]    LAST = W'(TICK_COUNT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_ck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pulse_blinker.sv
// Turns single-cycle event pulses into ON_MS-long LED blinks separated by
// OFF_MS dark gaps; events arriving mid-blink queue in a saturating counter.
module pulse_blinker
    import blink_defs::*;
#(
    parameter int TICK_COUNT = DEF_TICK_COUNT,
    parameter int ON_MS      = 200,
    parameter int OFF_MS     = 100,
    parameter int PEND_W     = 3
) (
    input  logic              i_ck,
    input  logic              i_reset_n,
    input  logic              i_event,
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
);

    localparam int                 MS_MAX   = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int                 MS_W     = cnt_w(MS_MAX);
    localparam logic [MS_W-1:0]    ON_LAST  = MS_W'(ON_MS - 1);
    localparam logic [MS_W-1:0]    OFF_LAST = MS_W'(OFF_MS - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    state_t              r_state;
    state_t              w_next;
    logic [MS_W-1:0]     r_ms;
    logic [PEND_W-1:0]   r_pend;
    logic                r_ovf;
    logic                w_tick;
    logic                w_done;
    logic                w_clear;
    logic                w_inc;
    logic                w_dec;
    logic                w_sat;

    assign w_done  = w_tick && (((r_state == ON)  && (r_ms == ON_LAST)) ||
                                ((r_state == OFF) && (r_ms == OFF_LAST)));
    assign w_clear = (r_state == IDLE) || w_done;

    ms_prescaler #(
        .TICK_COUNT (TICK_COUNT)
    ) u_prescaler (
        .i_ck      (i_ck),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .o_tick    (w_tick)
    );

    // An OFF->IDLE exit that queued an event leaves pending>0 in IDLE;
    // IDLE drains it on the next cycle just like a fresh event.
    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_event || (r_pend != '0)) begin
                    w_next = ON;
                    w_dec  = !i_event && (r_pend != '0);
                end
            end
            ON: begin
                w_inc = i_event;
                if (w_done) w_next = OFF;
            end
            OFF: begin
                w_inc = i_event;
                if (w_done) begin
                    if (r_pend != '0) begin
                        w_next = ON;
                        w_dec  = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_sat = (r_pend == PEND_MAX);

    always_ff @(posedge i_ck or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_ms    <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_ms <= '0;
            end else if (w_tick) begin
                r_ms <= r_ms + MS_W'(1);
            end
            if (w_inc && !w_dec && !w_sat) begin
                r_pend <= r_pend + PEND_W'(1);
            end else if (w_dec && !w_inc) begin
                r_pend <= r_pend - PEND_W'(1);
            end
            r_ovf <= w_inc && !w_dec && w_sat;
        end
    end

    assign o_led      = (r_state == ON);
    assign o_busy     = (r_state != IDLE);
    assign o_pending  = r_pend;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed + random bench for pulse_blinker against a phase/remaining-cycles
// reference model (TICK_COUNT=4, ON_MS=3, OFF_MS=2, PEND_W=2).
module tb_pulse_blinker;

    localparam int TICK    = 4;
    localparam int ON_MS   = 3;
    localparam int OFF_MS  = 2;
    localparam int PEND_W  = 2;
    localparam int ON_CYC  = ON_MS * TICK;
    localparam int OFF_CYC = OFF_MS * TICK;
    localparam int PMAX    = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              ev;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=dark/idle, 1=lit, 2=gap; m_rem = cycles left in phase.
    int m_mode, m_rem, m_pend;
    bit m_ovf;

    int led_cnt, busy_cnt, ovf_cnt, blinks;
    bit prev_led;

    pulse_blinker #(
        .TICK_COUNT (TICK),
        .ON_MS      (ON_MS),
        .OFF_MS     (OFF_MS),
        .PEND_W     (PEND_W)
    ) dut (
        .i_ck       (clk),
        .i_reset_n  (rst_n),
        .i_event    (ev),
        .o_led      (led),
        .o_busy     (busy),
        .o_pending  (pending),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_pend = 0; m_ovf = 0;
    endtask

    task automatic queue_event();
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
    endtask

    task automatic model_step(input bit e);
        bit last;
        last  = (m_mode != 0) && (m_rem == 1);
        m_ovf = 0;
        case (m_mode)
            0: if (e || m_pend > 0) begin
                if (!e) m_pend--;
                m_mode = 1; m_rem = ON_CYC;
            end
            1: begin
                if (e) queue_event();
                if (last) begin m_mode = 2; m_rem = OFF_CYC; end
                else m_rem--;
            end
            default: begin
                if (last) begin
                    if (m_pend > 0) begin
                        if (!e) m_pend--;
                        m_mode = 1; m_rem = ON_CYC;
                    end else begin
                        if (e) m_pend = 1;
                        m_mode = 0;
                    end
                end else begin
                    if (e) queue_event();
                    m_rem--;
                end
            end
        endcase
    endtask

    task automatic clr_stats();
        led_cnt = 0; busy_cnt = 0; ovf_cnt = 0; blinks = 0;
    endtask

    task automatic cycle(input bit e);
        ev = e;
        @(posedge clk);
        model_step(e);
        #1;
        chk("led",      led,      (m_mode == 1));
        chk("busy",     busy,     (m_mode != 0));
        chk("pending",  pending,  m_pend);
        chk("overflow", overflow, m_ovf);
        led_cnt  += led;
        busy_cnt += busy;
        ovf_cnt  += overflow;
        if (led && !prev_led) blinks++;
        prev_led = led;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && !(m_mode == 0 && m_pend == 0); i++) cycle(1'b0);
        cycle(1'b0);
        chk("drained_busy", busy, 0);
    endtask

    initial begin
        ev = 1'b0;
        prev_led = 1'b0;
        rst_n = 1'b0;
        model_reset();
        clr_stats();
        #12;
        chk("reset_led", led, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single event: 12 lit cycles, 20 busy cycles.
        repeat (9) cycle(1'b0);
        clr_stats();
        cycle(1'b1);
        repeat (30) cycle(1'b0);
        chk("single_led_cycles", led_cnt, ON_CYC);
        chk("single_busy_cycles", busy_cnt, ON_CYC + OFF_CYC);
        chk("single_blinks", blinks, 1);

        // Three queued events: four blinks, 80 busy cycles.
        clr_stats();
        cycle(1'b1);
        repeat (3) begin cycle(1'b1); cycle(1'b0); end
        drain();
        chk("three_busy_cycles", busy_cnt, 4 * (ON_CYC + OFF_CYC));
        chk("three_blinks", blinks, 4);
        chk("three_ovf", ovf_cnt, 0);

        // Five queued events: saturate at 3, two overflows, four blinks.
        clr_stats();
        cycle(1'b1);
        repeat (5) begin cycle(1'b1); cycle(1'b0); end
        chk("sat_pending", pending, PMAX);
        drain();
        chk("sat_ovf", ovf_cnt, 2);
        chk("sat_blinks", blinks, 4);

        // Event on OFF->ON exit at saturation, then on OFF->IDLE exit.
        clr_stats();
        cycle(1'b1);
        repeat (3) begin cycle(1'b1); cycle(1'b0); end
        for (int i = 0; i < 100 && !(m_mode == 2 && m_rem == 1); i++) cycle(1'b0);
        cycle(1'b1);
        chk("exit_sat_pending", pending, PMAX);
        chk("exit_sat_ovf", overflow, 0);
        for (int i = 0; i < 300 && !(m_mode == 2 && m_rem == 1 && m_pend == 0); i++) cycle(1'b0);
        cycle(1'b1);
        chk("exit_idle_pending", pending, 1);
        cycle(1'b0);
        chk("exit_idle_restart", led, 1);
        drain();
        chk("exit_blinks", blinks, 6);
        chk("exit_ovf", ovf_cnt, 0);

        // Asynchronous reset mid-ON with two queued events.
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        repeat (3) cycle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_led", led, 0);
        chk("areset_busy", busy, 0);
        chk("areset_pending", pending, 0);
        model_reset();
        #1 rst_n = 1'b1;
        clr_stats();
        repeat (30) cycle(1'b0);
        chk("areset_no_blink", blinks, 0);

        // Event held three cycles from IDLE.
        clr_stats();
        repeat (3) cycle(1'b1);
        chk("held_pending", pending, 2);
        drain();
        chk("held_blinks", blinks, 3);

        // Random event traffic.
        for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 9) == 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
